// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants: data width and PC-select encodings.
package legv8_pkg;

  // Datapath width for the 64-bit LEGv8 core.
  localparam int unsigned XLEN = 64;

  // PC-select (PS) codes driven by the control unit.
  localparam logic [1:0] PS_HOLD   = 2'b00;  // stall / halt
  localparam logic [1:0] PS_INC    = 2'b01;  // sequential, PC + 4
  localparam logic [1:0] PS_LOAD   = 2'b10;  // absolute target from in
  localparam logic [1:0] PS_BRANCH = 2'b11;  // PC + (in << 2)

  // Bytes per instruction word; used for both PC4 and sequential fetch.
  localparam logic [XLEN-1:0] INSTR_BYTES = 64'd4;

endpackage

// File: rtl/program_counter2_if.sv
// Bus between the control/datapath and the program-counter unit.
interface program_counter2_if;
  import legv8_pkg::*;

  logic [1:0]      PS;   // PC-select code
  logic [XLEN-1:0] in;   // absolute target or sign-extended word offset
  logic [XLEN-1:0] PC;   // current instruction address
  logic [XLEN-1:0] PC4;  // PC + 4 for the link/return path

  // Control side: chooses the next PC and observes the current one.
  modport master (
    output PS,
    output in,
    input  PC,
    input  PC4
  );

  // PC unit side.
  modport slave (
    input  PS,
    input  in,
    output PC,
    output PC4
  );

endinterface

// File: rtl/pc_register.sv
// 64-bit D register with synchronous active-high reset; holds the PC.
module pc_register
  import legv8_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // Load the next PC every edge; reset wins over any data.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/program_counter2.sv
// LEGv8 program-counter unit: PC register plus next-PC adders and 4:1 select.
module program_counter2
  import legv8_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  program_counter2_if.slave  bus
);

  // Net names kept as-is so they can be probed hierarchically.
  logic [XLEN-1:0] regOut;
  logic [XLEN-1:0] addOut;
  logic [XLEN-1:0] muxOut;
  logic [XLEN-1:0] branch_target;

  // Modulo-2^64 adds; carry-out is intentionally dropped so negative
  // two's-complement offsets branch backward and PC wraps to 0.
  assign addOut        = regOut + INSTR_BYTES;
  assign branch_target = regOut + (bus.in << 2);

  // Next-PC selection from the PS code.
  always_comb begin
    muxOut = regOut;
    unique case (bus.PS)
      PS_HOLD:   muxOut = regOut;
      PS_INC:    muxOut = addOut;
      PS_LOAD:   muxOut = bus.in;  // loaded as given, no alignment check
      PS_BRANCH: muxOut = branch_target;
      default:   muxOut = regOut;
    endcase
  end

  pc_register u_pc_register (
    .clock (clock),
    .reset (reset),
    .d     (muxOut),
    .q     (regOut)
  );

  assign bus.PC  = regOut;
  assign bus.PC4 = addOut;

endmodule

// File: tb/tb_program_counter2.sv
// Self-checking bench for program_counter2: directed cases and random PS/in
// traffic against an arithmetic reference model of the next-PC rules.
module tb_program_counter2;
  import legv8_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [63:0] model_pc;

  program_counter2_if bus ();

  program_counter2 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the next PC written straight from the selection rules.
  function automatic logic [63:0] next_pc(input logic r, input logic [1:0] ps,
                                          input logic [63:0] pc, input logic [63:0] din);
    if (r) return 64'd0;
    case (ps)
      2'd0:    return pc;
      2'd1:    return pc + 64'd4;
      2'd2:    return din;
      default: return pc + din * 64'd4;
    endcase
  endfunction

  // Apply one cycle of stimulus, advance the model, check both outputs.
  task automatic step(input string tag, input logic r, input logic [1:0] ps,
                      input logic [63:0] din);
    reset  = r;
    bus.PS = ps;
    bus.in = din;
    @(posedge clock);
    model_pc = next_pc(r, ps, model_pc, din);
    #1;
    check_eq({tag, "_pc"}, bus.PC, model_pc);
    check_eq({tag, "_pc4"}, bus.PC4, model_pc + 64'd4);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] fixed_in;
    logic [1:0]  rot_ps;
    checks   = 0;
    errors   = 0;
    model_pc = 64'd0;
    reset    = 1'b1;
    bus.PS   = PS_INC;
    bus.in   = '0;
    @(negedge clock);

    // Reset with PS=01 and random in, then hold.
    step("reset", 1'b1, PS_INC, rand64());
    check_eq("reset_pc_const", bus.PC, 64'd0);
    check_eq("reset_pc4_const", bus.PC4, 64'd4);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, PS_HOLD, rand64());
    check_eq("hold_const", bus.PC, 64'd0);

    // Increment.
    for (int i = 1; i <= 3; i++) begin
      step("inc", 1'b0, PS_INC, rand64());
      check_eq("inc_const", bus.PC, 64'(4 * i));
      check_eq("inc_pc4_const", bus.PC4, 64'(4 * i + 4));
    end

    // Absolute load.
    step("load", 1'b0, PS_LOAD, 64'h0000_0000_DEAD_BEE0);
    check_eq("load_const", bus.PC, 64'h0000_0000_DEAD_BEE0);
    check_eq("load_pc4_const", bus.PC4, 64'h0000_0000_DEAD_BEE4);

    // Branch forward then backward by one word.
    step("ld100", 1'b0, PS_LOAD, 64'h100);
    step("br_fwd", 1'b0, PS_BRANCH, 64'd5);
    check_eq("br_fwd_const", bus.PC, 64'h114);
    step("br_back", 1'b0, PS_BRANCH, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("br_back_const", bus.PC, 64'h110);
    check_eq("probe_addOut", dut.addOut, 64'h114);

    // Rotating PS with a fixed random operand.
    fixed_in = {$urandom, 16'h0, $urandom_range(0, 65535)};
    rot_ps   = PS_HOLD;
    for (int i = 0; i < 12; i++) begin
      step("rot", 1'b0, rot_ps, fixed_in);
      if (i % 3 == 2) rot_ps = rot_ps + 2'd1;
    end

    // Wrap-around and mid-run reset beats PS=10.
    step("ld_top", 1'b0, PS_LOAD, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("top_pc4_const", bus.PC4, 64'd0);
    step("wrap", 1'b0, PS_INC, rand64());
    check_eq("wrap_const", bus.PC, 64'd0);
    step("ld_mid", 1'b0, PS_LOAD, 64'h1234_5678);
    step("mid_rst", 1'b1, PS_LOAD, 64'hCAFE_F00D);
    check_eq("mid_rst_const", bus.PC, 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] din;
      din = ($urandom_range(0, 1) == 0) ? rand64()
          : 64'($signed(32'($urandom_range(0, 2000)) - 32'sd1000));
      step("rand", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), din);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
